// File: rtl/clk_sched_pkg.sv
// rtl/clk_sched_pkg.sv - shared types and defaults for the clock-enable scheduler
package clk_sched_pkg;

  localparam int DIV_W_DEF  = 16;
  localparam int TICK_W_DEF = 32;
  localparam int FREE_RUN   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/clk_en_sched_if.sv
// rtl/clk_en_sched_if.sv - run handshake, config and enable-train signals of clk_en_sched
interface clk_en_sched_if #(
  parameter int DIV_W  = clk_sched_pkg::DIV_W_DEF,
  parameter int TICK_W = clk_sched_pkg::TICK_W_DEF
) ();

  logic              run_req;
  logic              run_ack;
  logic [DIV_W-1:0]  cfg_div;
  logic [TICK_W-1:0] cfg_burst;
  logic              cfg_upd;
  logic              clk_en;
  logic              phase;
  logic [TICK_W-1:0] tick_count;
  logic              busy;
  logic              done;

  modport master (
    output run_req, cfg_div, cfg_burst, cfg_upd,
    input  run_ack, clk_en, phase, tick_count, busy, done
  );

  modport slave (
    input  run_req, cfg_div, cfg_burst, cfg_upd,
    output run_ack, clk_en, phase, tick_count, busy, done
  );

endinterface

// File: rtl/clk_div_counter.sv
// rtl/clk_div_counter.sv - divide counter with shadow ratio and pending reload on wrap
module clk_div_counter #(
  parameter int DIV_W = clk_sched_pkg::DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
  input  logic             run,
  input  logic             upd,
  input  logic [DIV_W-1:0] upd_div,
  output logic             wrap
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_sh;
  logic [DIV_W-1:0] pend;
  logic             pend_v;

  assign wrap = run && (cnt == div_sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      div_sh <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
    end else if (load) begin
      cnt    <= '0;
      div_sh <= load_div;
      pend   <= '0;
      pend_v <= 1'b0;
    end else if (run) begin
      if (cnt == div_sh) begin
        cnt <= '0;
        // An update landing on the wrap edge governs the very next period.
        if (upd) begin
          div_sh <= upd_div;
        end else if (pend_v) begin
          div_sh <= pend;
        end
        pend_v <= 1'b0;
      end else begin
        cnt <= cnt + DIV_W'(1);
        if (upd) begin
          pend   <= upd_div;
          pend_v <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/clk_en_sched.sv
// rtl/clk_en_sched.sv - programmable-rate clock-enable scheduler with req/ack start/stop
module clk_en_sched
  import clk_sched_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int TICK_W = TICK_W_DEF
) (
  input logic           clk,
  input logic           rst_n,
  clk_en_sched_if.slave bus
);

  state_t            state;
  state_t            state_nx;
  logic [TICK_W-1:0] burst_sh;
  logic [TICK_W-1:0] tick_inc;
  logic [TICK_W-1:0] tick_nx;
  logic              wrap;
  logic              start;
  logic              final_tick;
  logic              ack_nx;
  logic              en_nx;
  logic              phase_nx;
  logic              done_nx;
  logic              busy_nx;

  clk_div_counter #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .load_div (bus.cfg_div),
    .run      (state == RUN),
    .upd      (bus.cfg_upd && (state == RUN)),
    .upd_div  (bus.cfg_div),
    .wrap     (wrap)
  );

  assign tick_inc   = bus.tick_count + TICK_W'(1);
  assign final_tick = wrap && (burst_sh != TICK_W'(FREE_RUN)) && (tick_inc == burst_sh);

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    ack_nx   = bus.run_ack;
    en_nx    = 1'b0;
    done_nx  = 1'b0;
    phase_nx = bus.phase;
    tick_nx  = bus.tick_count;
    case (state)
      IDLE: begin
        if (bus.run_req) begin
          start    = 1'b1;
          tick_nx  = '0;
          phase_nx = 1'b0;
          state_nx = ARM;
        end
      end
      ARM: begin
        ack_nx   = 1'b1;
        state_nx = RUN;
      end
      RUN: begin
        // The closing burst tick still goes out even if req falls on that edge.
        if (wrap && (bus.run_req || final_tick)) begin
          en_nx    = 1'b1;
          tick_nx  = tick_inc;
          phase_nx = ~bus.phase;
          done_nx  = final_tick;
          if (final_tick) begin
            state_nx = HOLD;
          end
        end
        if (!bus.run_req) begin
          ack_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      HOLD: begin
        if (!bus.run_req) begin
          ack_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      burst_sh       <= '0;
      bus.run_ack    <= 1'b0;
      bus.clk_en     <= 1'b0;
      bus.phase      <= 1'b0;
      bus.tick_count <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state          <= state_nx;
      if (start) begin
        burst_sh <= bus.cfg_burst;
      end
      bus.run_ack    <= ack_nx;
      bus.clk_en     <= en_nx;
      bus.phase      <= phase_nx;
      bus.tick_count <= tick_nx;
      bus.busy       <= busy_nx;
      bus.done       <= done_nx;
    end
  end

endmodule

// File: tb/tb_clk_en_sched.sv
// tb/tb_clk_en_sched.sv - self-checking bench for clk_en_sched (schedule model + directed vectors)
module tb_clk_en_sched;

  localparam int DW = 16;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   cmp_on = 1'b0;

  clk_en_sched_if #(.DIV_W(DW), .TICK_W(TW)) bus ();

  clk_en_sched #(.DIV_W(DW), .TICK_W(TW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Schedule model: ticks are planned at absolute edge numbers from the start edge.
  int              m_mode;
  int              m_div;
  int              m_pend;
  bit              m_pend_v;
  int              m_next;
  logic [TW-1:0]   m_burst;
  logic [TW-1:0]   m_tc;
  logic [TW-1:0]   m_tc1;
  logic            m_ack, m_en, m_ph, m_busy, m_done;
  bit              is_tick, fin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_div = 0; m_pend = 0; m_pend_v = 0; m_next = 0;
      m_burst = '0; m_tc = '0;
      m_ack = 0; m_en = 0; m_ph = 0; m_busy = 0; m_done = 0;
    end else begin
      cyc = cyc + 1;
      m_en = 0;
      m_done = 0;
      case (m_mode)
        0: if (bus.run_req) begin
          m_div = int'(bus.cfg_div); m_burst = bus.cfg_burst;
          m_pend_v = 0; m_tc = '0; m_ph = 0; m_mode = 1;
        end
        1: begin
          m_ack = 1; m_mode = 2;
          m_next = cyc + m_div + 1;
        end
        2: begin
          is_tick = (cyc == m_next);
          m_tc1 = m_tc + 1'b1;
          fin = is_tick && (m_burst != 0) && (m_tc1 == m_burst);
          if (is_tick) begin
            if (bus.cfg_upd) m_div = int'(bus.cfg_div);
            else if (m_pend_v) m_div = m_pend;
            m_pend_v = 0;
            m_next = cyc + m_div + 1;
          end else if (bus.cfg_upd) begin
            m_pend = int'(bus.cfg_div); m_pend_v = 1;
          end
          if (is_tick && (bus.run_req || fin)) begin
            m_en = 1; m_tc = m_tc1; m_ph = ~m_ph; m_done = fin;
            if (fin) m_mode = 3;
          end
          if (!bus.run_req) begin m_mode = 0; m_ack = 0; end
        end
        default: if (!bus.run_req) begin m_mode = 0; m_ack = 0; end
      endcase
      m_busy = (m_mode != 0);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_run_ack",    bus.run_ack,    m_ack);
      chk("m_clk_en",     bus.clk_en,     m_en);
      chk("m_phase",      bus.phase,      m_ph);
      chk("m_tick_count", bus.tick_count, m_tc);
      chk("m_busy",       bus.busy,       m_busy);
      chk("m_done",       bus.done,       m_done);
    end
  end

  task automatic wait_tick(input string name, output int at);
    at = -1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.clk_en === 1'b1) begin
        at = cyc;
        break;
      end
    end
    n_cmp++;
    if (at < 0) begin
      n_bad++;
      $display("FAIL %s: no clk_en within 64 cycles, expected one", name);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t3, t4, t5, tc_frozen;
    rst_n = 1'b1;
    bus.run_req = 0; bus.cfg_div = '0; bus.cfg_burst = '0; bus.cfg_upd = 0;
    #3 rst_n = 1'b0;
    @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_ack", bus.run_ack, 0);
    chk("rst_en", bus.clk_en, 0);
    chk("rst_tick", bus.tick_count, 0);
    chk("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Free-run, ratio 3
    bus.cfg_div = 16'd3; bus.cfg_burst = '0; bus.run_req = 1;
    @(negedge clk);
    chk("t1_busy_e0", bus.busy, 1);
    chk("t1_ack_e0", bus.run_ack, 0);
    @(negedge clk);
    chk("t1_ack_e1", bus.run_ack, 1);
    chk("t1_en_e1", bus.clk_en, 0);
    repeat (3) @(negedge clk);
    chk("t1_en_e4", bus.clk_en, 0);
    @(negedge clk);
    chk("t1_en_e5", bus.clk_en, 1);
    chk("t1_tick_e5", bus.tick_count, 1);
    chk("t1_phase_e5", bus.phase, 1);
    t1 = cyc;
    wait_tick("t1_second", t2);
    chk("t1_gap", t2 - t1, 4);
    chk("t1_tick2", bus.tick_count, 2);
    chk("t1_phase2", bus.phase, 0);
    bus.run_req = 0;
    repeat (2) @(negedge clk);

    // Burst of 5 at full rate
    bus.cfg_div = 16'd0; bus.cfg_burst = 4'd5; bus.run_req = 1;
    wait_tick("t2_first", t1);
    chk("t2_tick1", bus.tick_count, 1);
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk);
      chk("t2_en", bus.clk_en, 1);
      chk("t2_tick", bus.tick_count, i);
      chk("t2_done", bus.done, (i == 5) ? 1 : 0);
    end
    @(negedge clk);
    chk("t2_hold_en", bus.clk_en, 0);
    chk("t2_hold_ack", bus.run_ack, 1);
    chk("t2_hold_busy", bus.busy, 1);
    repeat (3) @(negedge clk);
    chk("t2_hold_en_late", bus.clk_en, 0);
    bus.run_req = 0;
    @(negedge clk);
    chk("t2_stop_ack", bus.run_ack, 0);
    chk("t2_stop_busy", bus.busy, 0);
    @(negedge clk);

    // Ratio update mid-period, then on a wrap edge
    bus.cfg_div = 16'd4; bus.cfg_burst = '0; bus.run_req = 1;
    wait_tick("t3_first", t1);
    @(negedge clk);
    bus.cfg_upd = 1; bus.cfg_div = 16'd1;
    @(negedge clk);
    bus.cfg_upd = 0;
    wait_tick("t3_t2", t2);
    chk("t3_gap_keep", t2 - t1, 5);
    wait_tick("t3_t3", t3);
    chk("t3_gap_new", t3 - t2, 2);
    @(negedge clk);
    bus.cfg_upd = 1; bus.cfg_div = 16'd3;
    @(negedge clk);
    bus.cfg_upd = 0;
    chk("t3_wrap_en", bus.clk_en, 1);
    t4 = cyc;
    wait_tick("t3_t5", t5);
    chk("t3_gap_wrapupd", t5 - t4, 4);
    bus.run_req = 0;
    repeat (2) @(negedge clk);

    // Stop mid-period, freeze, restart clears
    bus.cfg_div = 16'd2; bus.run_req = 1;
    wait_tick("t4_first", t1);
    wait_tick("t4_second", t2);
    tc_frozen = 2;
    @(negedge clk);
    bus.run_req = 0;
    @(negedge clk);
    chk("t4_stop_ack", bus.run_ack, 0);
    chk("t4_stop_en", bus.clk_en, 0);
    repeat (4) begin
      @(negedge clk);
      chk("t4_frozen_en", bus.clk_en, 0);
      chk("t4_frozen_tick", bus.tick_count, tc_frozen);
    end
    bus.run_req = 1;
    @(negedge clk);
    chk("t4_restart_tick", bus.tick_count, 0);
    chk("t4_restart_busy", bus.busy, 1);

    // Asynchronous reset mid-run, right while clk_en is high
    wait_tick("t5_first", t1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_en", bus.clk_en, 0);
    chk("t5_rst_ack", bus.run_ack, 0);
    chk("t5_rst_tick", bus.tick_count, 0);
    chk("t5_rst_busy", bus.busy, 0);
    bus.run_req = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_idle_busy", bus.busy, 0);
    chk("t5_idle_ack", bus.run_ack, 0);

    // 4-bit tick counter wraps in free-run with no done
    bus.cfg_div = 16'd0; bus.cfg_burst = '0; bus.run_req = 1;
    wait_tick("t6_first", t1);
    chk("t6_tick1", bus.tick_count, 1);
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      chk("t6_en", bus.clk_en, 1);
      chk("t6_tick", bus.tick_count, k % 16);
      chk("t6_done", bus.done, 0);
    end
    bus.run_req = 0;
    repeat (2) @(negedge clk);
    chk("t6_stop_busy", bus.busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
